seg_scan: RTL and testbench

SEG_SCAN -- requirements
Module: seg_scan

---
 rtl/seg_scan_if.sv | 24 ++
 rtl/seg_scan.sv | 126 ++++++++++++
 tb/tb_seg_scan.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_if.sv
// seg_scan_if: display load bus and driven display lines of the multiplexed 7-segment scanner
interface seg_scan_if #(
    parameter int N_DIGITS = 4
);
    logic [4*N_DIGITS-1:0] value;
    logic [N_DIGITS-1:0]   dp;
    logic [N_DIGITS-1:0]   en;
    logic                  lz_blank;
    logic                  load;
    logic [6:0]            seg;
    logic                  dp_n;
    logic [N_DIGITS-1:0]   an;
    logic                  frame_done;

    modport master (
        output value, dp, en, lz_blank, load,
        input  seg, dp_n, an, frame_done
    );

    modport slave (
        input  value, dp, en, lz_blank, load,
        output seg, dp_n, an, frame_done
    );
endinterface

// File: rtl/seg_scan.sv
// seg_scan: tear-free multiplexed 7-segment scanner with guard gap, leading-zero blanking and hex decode
module seg_scan #(
    parameter int N_DIGITS    = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 2,
    parameter bit HEX_EN      = 1'b1
) (
    input logic       clk,
    input logic       rst,
    seg_scan_if.slave io_bus
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = N_DIGITS > 1 ? $clog2(N_DIGITS) : 1;
    localparam int DW = 4 * N_DIGITS;

    logic [CW-1:0]       r_cnt, w_cnt_nxt;
    logic [IW-1:0]       r_idx, w_idx_nxt;
    logic [DW-1:0]       r_sh_val, r_ac_val, w_ac_val;
    logic [N_DIGITS-1:0] r_sh_dp, r_sh_en, r_ac_dp, r_ac_en, w_ac_dp, w_ac_en;
    logic                r_sh_lz, r_ac_lz, w_ac_lz;
    logic                w_tick, w_wrap;
    logic [N_DIGITS-1:0] w_zero, w_an_sel;
    logic                w_run, w_guard, w_den, w_ddp, w_lzb;
    logic [3:0]          w_nib;
    logic [N_DIGITS-1:0] r_an;
    logic [6:0]          r_seg;
    logic                r_dp_n, r_fd;

    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'h0:    decode = 7'b1000000;
            4'h1:    decode = 7'b1111001;
            4'h2:    decode = 7'b0100100;
            4'h3:    decode = 7'b0110000;
            4'h4:    decode = 7'b0011001;
            4'h5:    decode = 7'b0010010;
            4'h6:    decode = 7'b0000010;
            4'h7:    decode = 7'b1111000;
            4'h8:    decode = 7'b0000000;
            4'h9:    decode = 7'b0010000;
            4'hA:    decode = HEX_EN ? 7'b0001000 : 7'b1111111;
            4'hB:    decode = HEX_EN ? 7'b0000011 : 7'b1111111;
            4'hC:    decode = HEX_EN ? 7'b1000110 : 7'b1111111;
            4'hD:    decode = HEX_EN ? 7'b0100001 : 7'b1111111;
            4'hE:    decode = HEX_EN ? 7'b0000110 : 7'b1111111;
            default: decode = HEX_EN ? 7'b0001110 : 7'b1111111;
        endcase
    endfunction

    // Next scan position; the active copy swaps in from the shadow only at the frame wrap
    always_comb begin
        w_tick    = r_cnt == CW'(REFRESH_DIV - 1);
        w_wrap    = w_tick && (r_idx == IW'(N_DIGITS - 1));
        w_cnt_nxt = w_tick ? '0 : r_cnt + 1'b1;
        w_idx_nxt = w_wrap ? '0 : (w_tick ? r_idx + 1'b1 : r_idx);
        w_ac_val  = w_wrap ? r_sh_val : r_ac_val;
        w_ac_dp   = w_wrap ? r_sh_dp : r_ac_dp;
        w_ac_en   = w_wrap ? r_sh_en : r_ac_en;
        w_ac_lz   = w_wrap ? r_sh_lz : r_ac_lz;
    end

    // Digit attributes for the position the outputs will show next cycle
    always_comb begin
        w_run  = 1'b1;
        w_zero = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            w_run     = w_run && (w_ac_val[4*i +: 4] == 4'd0);
            w_zero[i] = w_run;
        end
        w_nib    = w_ac_val[{w_idx_nxt, 2'b00} +: 4];
        w_den    = w_ac_en[w_idx_nxt];
        w_ddp    = w_ac_dp[w_idx_nxt];
        w_lzb    = w_ac_lz && w_zero[w_idx_nxt] && (w_idx_nxt != '0);
        w_guard  = w_cnt_nxt < CW'(GUARD);
        w_an_sel = ~(N_DIGITS'(1) << w_idx_nxt);
    end

    // Prescaler, digit index, shadow capture and frame-boundary active load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_idx    <= '0;
            r_sh_val <= '0;
            r_sh_dp  <= '0;
            r_sh_en  <= '0;
            r_sh_lz  <= 1'b0;
            r_ac_val <= '0;
            r_ac_dp  <= '0;
            r_ac_en  <= '0;
            r_ac_lz  <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_idx    <= w_idx_nxt;
            r_ac_val <= w_ac_val;
            r_ac_dp  <= w_ac_dp;
            r_ac_en  <= w_ac_en;
            r_ac_lz  <= w_ac_lz;
            if (io_bus.load) begin
                r_sh_val <= io_bus.value;
                r_sh_dp  <= io_bus.dp;
                r_sh_en  <= io_bus.en;
                r_sh_lz  <= io_bus.lz_blank;
            end
        end
    end

    // Registered display drive; a lone decimal point keeps its anode on under zero blanking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_an   <= '1;
            r_seg  <= 7'h7F;
            r_dp_n <= 1'b1;
            r_fd   <= 1'b0;
        end else begin
            r_fd   <= w_wrap;
            r_an   <= (w_guard || !w_den || (w_lzb && !w_ddp)) ? '1 : w_an_sel;
            r_seg  <= (w_guard || !w_den || w_lzb) ? 7'h7F : decode(w_nib);
            r_dp_n <= (w_guard || !w_den) ? 1'b1 : !w_ddp;
        end
    end

    assign io_bus.an         = r_an;
    assign io_bus.seg        = r_seg;
    assign io_bus.dp_n       = r_dp_n;
    assign io_bus.frame_done = r_fd;
endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: scoreboard bench for seg_scan, hex and blank-hex variants driven side by side
module tb_seg_scan;
    localparam int N  = 4;
    localparam int RD = 4;
    localparam int G  = 1;
    localparam int FR = N * RD;

    typedef struct packed {
        logic [N-1:0] an;
        logic [6:0]   seg;
        logic         dp_n;
        logic         fd;
    } out_t;

    typedef struct packed {
        logic [4*N-1:0] val;
        logic [N-1:0]   dp;
        logic [N-1:0]   en;
        logic           lz;
    } data_t;

    localparam out_t RST_O = {4'hF, 7'h7F, 1'b1, 1'b0};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    data_t drv = '0;
    logic  drv_load = 1'b0;

    seg_scan_if #(.N_DIGITS(N)) bh ();
    seg_scan_if #(.N_DIGITS(N)) bb ();

    assign bh.value = drv.val;
    assign bh.dp = drv.dp;
    assign bh.en = drv.en;
    assign bh.lz_blank = drv.lz;
    assign bh.load = drv_load;
    assign bb.value = drv.val;
    assign bb.dp = drv.dp;
    assign bb.en = drv.en;
    assign bb.lz_blank = drv.lz;
    assign bb.load = drv_load;

    seg_scan #(.N_DIGITS(N), .REFRESH_DIV(RD), .GUARD(G), .HEX_EN(1'b1)) dut_h (.clk(clk), .rst(rst), .io_bus(bh));
    seg_scan #(.N_DIGITS(N), .REFRESH_DIV(RD), .GUARD(G), .HEX_EN(1'b0)) dut_b (.clk(clk), .rst(rst), .io_bus(bb));

    logic [6:0] glyph [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    int    errors = 0;
    int    checks = 0;
    int    e = 0;
    data_t shadow = '0;
    data_t active = '0;
    out_t  q_h[$];
    out_t  q_b[$];

    // Expected display after e clock edges since reset: digit slot e/RD, phase e%RD within the slot
    function automatic out_t expect_out(data_t a, int ecnt, bit hex);
        out_t       o;
        int         d;
        int         ph;
        logic [3:0] nib;
        bit         lzb;
        d      = (ecnt / RD) % N;
        ph     = ecnt % RD;
        o.an   = '1;
        o.seg  = 7'h7F;
        o.dp_n = 1'b1;
        o.fd   = (ecnt % FR) == 0;
        if (ph >= G && a.en[d]) begin
            nib = a.val[4*d +: 4];
            lzb = a.lz && d != 0 && ((a.val >> (4 * d)) == 0);
            o.dp_n = ~a.dp[d];
            if (lzb) begin
                if (a.dp[d]) o.an[d] = 1'b0;
            end else begin
                o.an[d] = 1'b0;
                o.seg = (!hex && nib > 4'd9) ? 7'h7F : glyph[nib];
            end
        end
        return o;
    endfunction

    // Reference model: frame-level shadow/active behaviour, one expectation pushed per clock edge
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                e = 0;
                shadow = '0;
                active = '0;
                q_h.push_back(RST_O);
                q_b.push_back(RST_O);
            end else begin
                e++;
                if (e % FR == 0) active = shadow;
                if (drv_load) shadow = drv;
                q_h.push_back(expect_out(active, e, 1'b1));
                q_b.push_back(expect_out(active, e, 1'b0));
            end
        end
    end

    task automatic check(string nm, out_t act, out_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got an=%b seg=%b dp_n=%b fd=%b expected an=%b seg=%b dp_n=%b fd=%b",
                     nm, $time, act.an, act.seg, act.dp_n, act.fd, exp.an, exp.seg, exp.dp_n, exp.fd);
        end
        checks++;
        if ($countones(~act.an) > 1) begin
            errors++;
            $display("FAIL %s_onehot t=%0t an=%b expected at most one low bit", nm, $time, act.an);
        end
    endtask

    // Monitor: pops the expectation for the current cycle; while rst is high the display must be dark at once
    initial begin
        out_t eh, eb;
        forever begin
            @(negedge clk);
            if (q_h.size() == 0 || q_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL queue_empty t=%0t got no expectation required one", $time);
            end else begin
                eh = q_h.pop_front();
                eb = q_b.pop_front();
                if (rst) begin
                    eh = RST_O;
                    eb = RST_O;
                end
                check("hex", {bh.an, bh.seg, bh.dp_n, bh.frame_done}, eh);
                check("nohex", {bb.an, bb.seg, bb.dp_n, bb.frame_done}, eb);
            end
        end
    end

    task automatic run(int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic pulse(data_t d);
        drv = d;
        drv_load = 1'b1;
        run(1);
        drv_load = 1'b0;
    endtask

    task automatic wait_phase(int p);
        for (int i = 0; i < 2 * FR; i++) begin
            if (e % FR == p) return;
            run(1);
        end
        checks++;
        errors++;
        $display("FAIL wait_phase got no phase %0d within %0d cycles", p, 2 * FR);
    endtask

    function automatic data_t mk(logic [15:0] v, logic [3:0] dp, logic [3:0] en, logic lz);
        data_t d;
        d.val = v;
        d.dp = dp;
        d.en = en;
        d.lz = lz;
        return d;
    endfunction

    initial begin
        logic [15:0] v;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        run(3 * FR);
        pulse(mk(16'h1234, 4'h0, 4'hF, 1'b0));
        run(2 * FR + 3);
        pulse(mk(16'hABCD, 4'h0, 4'hF, 1'b0));
        run(2 * FR);
        pulse(mk(16'h0050, 4'b1000, 4'hF, 1'b1));
        run(2 * FR);
        pulse(mk(16'h1111, 4'h0, 4'hF, 1'b0));
        wait_phase(FR - 1);
        pulse(mk(16'h2222, 4'h0, 4'hF, 1'b0));
        run(2 * FR + 2);
        pulse(mk(16'h5555, 4'h5, 4'hF, 1'b0));
        pulse(mk(16'h6789, 4'hA, 4'hE, 1'b0));
        run(2 * FR);
        pulse(mk(16'h0000, 4'h0, 4'hF, 1'b1));
        run(2 * FR);
        for (int k = 0; k < 24; k++) begin
            v = 16'($urandom);
            v = v >> (4 * $urandom_range(0, 3));
            pulse(mk(v, 4'($urandom), 4'($urandom), 1'($urandom)));
            run($urandom_range(0, 2 * FR));
        end
        run(2 * FR);
        pulse(mk(16'h1234, 4'h4, 4'hF, 1'b0));
        run(FR);
        wait_phase(10);
        rst = 1'b1;
        run(3);
        rst = 1'b0;
        run(3 * FR);
        pulse(mk(16'h9870, 4'h1, 4'hF, 1'b1));
        run(2 * FR);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no finish by %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
